// File: rtl/cmd_pkg.sv
// cmd_pkg: shared definitions for the serial command parser.
//   state_t       - parser FSM state encoding
//   CH_*          - ASCII characters with protocol meaning
//   ARG_LETTERS   - command letters that take a binary argument
//   isArgLetter() - true for a letter in ARG_LETTERS
//   isLetter()    - true for 'A'..'Z' or 'a'..'z'
package cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_ARG,
    GET_IDX,
    EXEC,
    SEND_HI,
    SEND_LO,
    ACK,
    NAK
  } state_t;

  localparam logic [7:0] CH_ACK      = 8'h2A;  // '*'
  localparam logic [7:0] CH_NAK      = 8'h21;  // '!'
  localparam logic [7:0] CH_QUERY    = 8'h3F;  // '?'
  localparam logic [7:0] CH_RESET    = 8'h52;  // 'R'
  localparam logic [7:0] CH_ECHO_ON  = 8'h45;  // 'E'
  localparam logic [7:0] CH_ECHO_OFF = 8'h65;  // 'e'
  localparam logic [7:0] CH_ZERO     = 8'h30;  // '0'
  localparam logic [7:0] CH_ONE      = 8'h31;  // '1'
  localparam logic [7:0] CH_NINE     = 8'h39;  // '9'

  localparam int NUM_ARG_LETTERS = 3;
  localparam logic [8*NUM_ARG_LETTERS-1:0] ARG_LETTERS = {8'h56, 8'h59, 8'h4B};  // 'V','Y','K'

  function automatic logic isArgLetter(input logic [7:0] c);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_ARG_LETTERS; i++) begin
      if (c == ARG_LETTERS[8*i +: 8]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic isLetter(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

endpackage

// File: rtl/hex_nibble_ascii.sv
// hex_nibble_ascii: converts a 4-bit value to its uppercase ASCII hex digit.
//   nibble - binary value 0..15
//   ascii  - '0'..'9' or 'A'..'F'
module hex_nibble_ascii
  import cmd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // 'A' - 10 = 0x37, so letters reuse the same adder with a different base.
  always_comb begin
    if (nibble < 4'd10) ascii = CH_ZERO + {4'h0, nibble};
    else                ascii = 8'h37 + {4'h0, nibble};
  end

endmodule

// File: rtl/cmd_parser.sv
// cmd_parser: single-character UART command parser.
//   clk, rst_n         - clock, synchronous active-low reset
//   rxData, rxValid    - received character and its one-cycle strobe
//   txData, txDataWr   - character to UART and its write strobe
//   txReady            - UART accepts a write this cycle
//   statusIn           - NUM_STATUS packed 8-bit status channels
//   cmdValid           - one-cycle command strobe with cmdCode/cmdArg
//   echoEn             - echo mode flag
//   busy               - FSM not in IDLE
module cmd_parser
  import cmd_pkg::*;
#(
  parameter int ARG_BITS       = 16,
  parameter int NUM_STATUS     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rxData,
  input  logic                    rxValid,
  output logic [7:0]              txData,
  output logic                    txDataWr,
  input  logic                    txReady,
  input  logic [8*NUM_STATUS-1:0] statusIn,
  output logic                    cmdValid,
  output logic [7:0]              cmdCode,
  output logic [ARG_BITS-1:0]     cmdArg,
  output logic                    echoEn,
  output logic                    busy
);

  localparam int CNT_W  = $clog2(ARG_BITS + 1);
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t              state;
  logic [ARG_BITS-1:0] shiftReg;
  logic [CNT_W-1:0]    bitCnt;
  logic [IDLE_W-1:0]   idleCnt;
  logic [7:0]          statusByte;
  logic                echoFull;
  logic [7:0]          echoByte;
  logic                rxReset;
  logic                isDigit;
  logic                statusHit;
  logic [7:0]          statusSel;
  logic [3:0]          hexNibble;
  logic [7:0]          hexChar;
  logic                respPending;
  logic [7:0]          respByte;
  logic                echoWr;
  logic                respWr;

  assign rxReset  = rxValid && (rxData == CH_RESET);
  assign isDigit  = (rxData >= CH_ZERO) && (rxData <= CH_NINE);
  assign busy     = (state != IDLE);
  assign cmdValid = (state == EXEC);

  always_comb begin
    statusHit = 1'b0;
    statusSel = 8'h00;
    for (int i = 0; i < NUM_STATUS; i++) begin
      if (isDigit && (rxData[3:0] == 4'(i))) begin
        statusHit = 1'b1;
        statusSel = statusIn[8*i +: 8];
      end
    end
  end

  assign hexNibble = (state == SEND_HI) ? statusByte[7:4] : statusByte[3:0];

  hex_nibble_ascii uHex (
    .nibble (hexNibble),
    .ascii  (hexChar)
  );

  always_comb begin
    respPending = 1'b1;
    case (state)
      SEND_HI, SEND_LO: respByte = hexChar;
      ACK:              respByte = CH_ACK;
      NAK:              respByte = CH_NAK;
      default: begin
        respByte    = 8'h00;
        respPending = 1'b0;
      end
    endcase
  end

  // Echo wins the UART; a stalled FSM response simply waits in its state.
  assign echoWr   = txReady && echoFull;
  assign respWr   = txReady && !echoFull && respPending;
  assign txDataWr = rst_n && (echoWr || respWr);
  assign txData   = !rst_n ? 8'h00 : echoWr ? echoByte : respWr ? respByte : 8'h00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmdCode    <= 8'h00;
      cmdArg     <= '0;
      echoEn     <= 1'b0;
      shiftReg   <= '0;
      bitCnt     <= '0;
      idleCnt    <= '0;
      statusByte <= 8'h00;
      echoFull   <= 1'b0;
      echoByte   <= 8'h00;
    end else begin
      // Echo buffer: a newer character overwrites an unsent one.
      if (rxReset)                begin echoFull <= 1'b0; end
      else if (rxValid && echoEn) begin echoFull <= 1'b1; echoByte <= rxData; end
      else if (echoWr)            begin echoFull <= 1'b0; end

      if (rxReset) begin
        state    <= IDLE;
        shiftReg <= '0;
        bitCnt   <= '0;
        idleCnt  <= '0;
      end else begin
        case (state)
          IDLE: if (rxValid) begin
            if (isArgLetter(rxData)) begin
              cmdCode  <= rxData;
              shiftReg <= '0;
              bitCnt   <= '0;
              idleCnt  <= '0;
              state    <= GET_ARG;
            end else if (rxData == CH_QUERY) begin
              idleCnt <= '0;
              state   <= GET_IDX;
            end else if (rxData == CH_ECHO_ON) begin
              echoEn <= 1'b1;
              state  <= ACK;
            end else if (rxData == CH_ECHO_OFF) begin
              echoEn <= 1'b0;
              state  <= ACK;
            end else if (isLetter(rxData)) begin
              cmdCode <= rxData;
              cmdArg  <= '0;
              state   <= EXEC;
            end else begin
              state <= NAK;
            end
          end
          GET_ARG: begin
            if (bitCnt == CNT_W'(ARG_BITS)) begin
              cmdArg <= shiftReg;
              state  <= EXEC;
            end else if (rxValid) begin
              idleCnt <= '0;
              if ((rxData == CH_ZERO) || (rxData == CH_ONE)) begin
                shiftReg <= (shiftReg << 1) | ARG_BITS'(rxData[0]);
                bitCnt   <= bitCnt + 1'b1;
              end else begin
                shiftReg <= '0;
                bitCnt   <= '0;
                state    <= NAK;
              end
            end else if (idleCnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
              shiftReg <= '0;
              bitCnt   <= '0;
              idleCnt  <= '0;
              state    <= NAK;
            end else begin
              idleCnt <= idleCnt + 1'b1;
            end
          end
          GET_IDX: begin
            if (rxValid) begin
              idleCnt <= '0;
              if (statusHit) begin
                statusByte <= statusSel;
                state      <= SEND_HI;
              end else begin
                state <= NAK;
              end
            end else if (idleCnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
              idleCnt <= '0;
              state   <= NAK;
            end else begin
              idleCnt <= idleCnt + 1'b1;
            end
          end
          EXEC:    state <= ACK;
          SEND_HI: if (respWr) state <= SEND_LO;
          SEND_LO, ACK, NAK: if (respWr) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_parser.sv
// tb_cmd_parser: directed stimulus with a queue scoreboard for cmd_parser.
module tb_cmd_parser;

  localparam int ARG_BITS       = 16;
  localparam int NUM_STATUS     = 4;
  localparam int TIMEOUT_CYCLES = 100;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [7:0]              rxData;
  logic                    rxValid;
  logic [7:0]              txData;
  logic                    txDataWr;
  logic                    txReady;
  logic [8*NUM_STATUS-1:0] statusIn;
  logic                    cmdValid;
  logic [7:0]              cmdCode;
  logic [ARG_BITS-1:0]     cmdArg;
  logic                    echoEn;
  logic                    busy;

  int checksTotal  = 0;
  int checksPassed = 0;

  logic [7:0]  txQ[$];
  logic [23:0] cmdQ[$];
  logic [7:0]  monExpTx;
  logic [23:0] monExpCmd;

  cmd_parser #(
    .ARG_BITS       (ARG_BITS),
    .NUM_STATUS     (NUM_STATUS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxData   (rxData),
    .rxValid  (rxValid),
    .txData   (txData),
    .txDataWr (txDataWr),
    .txReady  (txReady),
    .statusIn (statusIn),
    .cmdValid (cmdValid),
    .cmdCode  (cmdCode),
    .cmdArg   (cmdArg),
    .echoEn   (echoEn),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every UART write and command strobe must match the head of its queue.
  always @(negedge clk) begin
    if (txDataWr === 1'b1) begin
      if (txQ.size() == 0) begin
        checksTotal++;
        $display("FAIL tx_unexpected: got write of 0x%0h, expected no write", txData);
      end else begin
        monExpTx = txQ.pop_front();
        check("tx_byte", {24'h0, txData}, {24'h0, monExpTx});
      end
    end
    if (cmdValid === 1'b1) begin
      if (cmdQ.size() == 0) begin
        checksTotal++;
        $display("FAIL cmd_unexpected: got code 0x%0h arg 0x%0h, expected no command", cmdCode, cmdArg);
      end else begin
        monExpCmd = cmdQ.pop_front();
        check("cmd_code_arg", {8'h0, cmdCode, cmdArg}, {8'h0, monExpCmd});
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no end of test, expected finish within 20000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendChar(input logic [7:0] c);
    rxData  = c;
    rxValid = 1'b1;
    @(posedge clk);
    #1;
    rxValid = 1'b0;
    rxData  = 8'h00;
  endtask

  task automatic sendStr(input string s);
    for (int i = 0; i < s.len(); i++) sendChar(s[i]);
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, {31'h0, busy}, 32'h0);
    idle(2);
  endtask

  task automatic checkResetOutputs(input string tag);
    @(negedge clk);
    check({tag, "_txDataWr"}, {31'h0, txDataWr}, 32'h0);
    check({tag, "_txData"},   {24'h0, txData},   32'h0);
    check({tag, "_cmdValid"}, {31'h0, cmdValid}, 32'h0);
    check({tag, "_cmdCode"},  {24'h0, cmdCode},  32'h0);
    check({tag, "_cmdArg"},   {16'h0, cmdArg},   32'h0);
    check({tag, "_echoEn"},   {31'h0, echoEn},   32'h0);
    check({tag, "_busy"},     {31'h0, busy},     32'h0);
  endtask

  initial begin
    rst_n    = 1'b0;
    rxValid  = 1'b0;
    rxData   = 8'h00;
    txReady  = 1'b0;
    statusIn = 32'h11A5_3C00;  // ch3=0x11 ch2=0xA5 ch1=0x3C ch0=0x00

    repeat (3) @(posedge clk);
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    txReady = 1'b1;
    idle(2);

    // Argument command, MSB first
    cmdQ.push_back({8'h56, 16'h0103});
    txQ.push_back(8'h2A);
    sendStr("V0000000100000011");
    waitIdle("idle_after_V");

    // Status queries, including out-of-range indices
    txQ.push_back(8'h41); txQ.push_back(8'h35);
    sendStr("?2");
    waitIdle("idle_after_q2");
    txQ.push_back(8'h33); txQ.push_back(8'h43);
    sendStr("?1");
    waitIdle("idle_after_q1");
    txQ.push_back(8'h21);
    sendStr("?9");
    waitIdle("idle_after_q9");
    txQ.push_back(8'h21);
    sendStr("?4");
    waitIdle("idle_after_q4");

    // 'R' aborts a partial argument silently
    sendStr("V101R");
    check("busy_after_R", {31'h0, busy}, 32'h0);
    idle(5);
    cmdQ.push_back({8'h54, 16'h0000});
    txQ.push_back(8'h2A);
    sendStr("T");
    waitIdle("idle_after_T");

    // Non-letter, bad argument digit, all-ones argument
    txQ.push_back(8'h21);
    sendStr("#");
    waitIdle("idle_after_hash");
    txQ.push_back(8'h21);
    sendStr("V10x");
    waitIdle("idle_after_badarg");
    cmdQ.push_back({8'h59, 16'hFFFF});
    txQ.push_back(8'h2A);
    sendChar(8'h59);
    repeat (16) sendChar(8'h31);
    waitIdle("idle_after_Y");

    // Inter-character timeout
    txQ.push_back(8'h21);
    sendStr("V1");
    idle(90);
    check("busy_before_timeout", {31'h0, busy}, 32'h1);
    idle(20);
    check("busy_after_timeout", {31'h0, busy}, 32'h0);
    idle(2);

    // Echo on; stalled UART; overwritten echo precedes the ack
    txQ.push_back(8'h2A);
    sendChar(8'h45);
    waitIdle("idle_after_E");
    check("echoEn_on", {31'h0, echoEn}, 32'h1);
    txReady = 1'b0;
    cmdQ.push_back({8'h54, 16'h0000});
    txQ.push_back(8'h78);
    txQ.push_back(8'h2A);
    sendChar(8'h54);
    idle(3);
    sendChar(8'h78);
    idle(46);
    txReady = 1'b1;
    waitIdle("idle_after_echo_Tx");
    txQ.push_back(8'h65);
    txQ.push_back(8'h2A);
    sendChar(8'h65);
    waitIdle("idle_after_e");
    check("echoEn_off", {31'h0, echoEn}, 32'h0);

    // Reset while the low nibble is stalled
    txReady = 1'b0;
    sendStr("?2");
    txQ.push_back(8'h41);
    txReady = 1'b1;
    @(posedge clk);
    #1;
    txReady = 1'b0;
    check("busy_in_send_lo", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    checkResetOutputs("midtx");
    #1;
    txReady = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(10);

    check("txQ_drained",  txQ.size(),  32'h0);
    check("cmdQ_drained", cmdQ.size(), 32'h0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/cmd_parser.md
CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001 SHALL have parameter ARG_BITS, default 16: binary argument width, 1..32.
REQ-002 SHALL have parameter NUM_STATUS, default 4: number of 8-bit status channels, 1..10.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000: inter-character timeout while collecting an argument or status index.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  synchronous reset, active low.
REQ-005 SHALL have ports: rxData  in  8  received character; rxValid  in  1  one-cycle strobe qualifying rxData.
REQ-006 SHALL have ports: txData  out  8  character to UART; txDataWr  out  1  one-cycle write strobe; txReady  in  1  UART can accept a write this cycle.
REQ-007 SHALL have ports: statusIn  in  8*NUM_STATUS  status channels, channel n at bits [8n+7:8n].
REQ-008 SHALL have ports: cmdValid  out  1  one-cycle command strobe; cmdCode  out  8  command letter; cmdArg  out  ARG_BITS  collected argument, zero for plain commands.
REQ-009 SHALL have ports: echoEn  out  1  echo mode flag; busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL implement states IDLE, GET_ARG, GET_IDX, EXEC, SEND_HI, SEND_LO, ACK, NAK.
REQ-011 In IDLE, rxValid with an argument letter ('V','Y','K') SHALL latch cmdCode, clear the shift register and bit count, and go to GET_ARG.
REQ-012 In IDLE, rxValid with '?' SHALL go to GET_IDX.
REQ-013 In IDLE, 'E' and 'e' SHALL set and clear echoEn respectively, then go to ACK.
REQ-014 In IDLE, any other letter 'A'..'Z' or 'a'..'z' SHALL latch cmdCode, set cmdArg = 0, and go to EXEC.
REQ-015 In IDLE, any non-letter character SHALL go to NAK.
REQ-016 In GET_ARG, '0' or '1' SHALL shift in at the LSB (MSB first) and increment the count.
REQ-017 When the count reaches ARG_BITS, GET_ARG SHALL go to EXEC on the following cycle.
REQ-018 Any other character in GET_ARG SHALL go to NAK.
REQ-019 In GET_IDX, digit d < NUM_STATUS SHALL latch statusIn channel d and go to SEND_HI.
REQ-020 Any other character in GET_IDX SHALL go to NAK.
REQ-021 EXEC SHALL assert cmdValid for exactly one cycle with cmdCode and cmdArg stable, then go to ACK.
REQ-022 SEND_HI and SEND_LO SHALL transmit the upper and lower nibble of the latched byte as uppercase ASCII hex ('0'-'9', 'A'-'F'), then go to IDLE.
REQ-023 ACK SHALL transmit '*' and NAK SHALL transmit '!', each then going to IDLE.
REQ-024 Every transmitting state SHALL pulse txDataWr only in a cycle where txReady = 1, and SHALL hold the state until that write occurs.
REQ-025 Echo: when echoEn = 1, each accepted rxValid character SHALL be stored in a one-byte echo buffer.
REQ-026 The echo buffer SHALL have priority over FSM responses for the next txReady cycle.
REQ-027 If the echo buffer is still full when a new character arrives, the buffer SHALL be overwritten; FSM responses SHALL never be dropped.
REQ-028 An idle counter SHALL run in GET_ARG and GET_IDX, resetting on every rxValid.
REQ-029 When the idle counter reaches TIMEOUT_CYCLES - 1, the FSM SHALL go to NAK and discard the partial argument.
REQ-030 rxValid 'R' SHALL force IDLE from any state on the next edge, clearing the counters and the echo buffer.
REQ-031 'R' SHALL NOT pulse cmdValid, SHALL NOT send a response, and SHALL NOT change echoEn.
REQ-032 rxValid arriving in EXEC, ACK, NAK, SEND_HI or SEND_LO SHALL be ignored, except 'R' and the echo.

Reset
REQ-033 While rst_n = 0 at a clk edge, the FSM SHALL enter IDLE.
REQ-034 During reset: txDataWr = 0, txData = 0, cmdValid = 0, cmdCode = 0, cmdArg = 0, echoEn = 0, busy = 0.
REQ-035 During reset, all counters and the echo buffer SHALL clear.
REQ-036 Reset mid-transmission SHALL abandon the pending byte.

Structure
REQ-037 A shared package cmd_pkg SHALL hold the state encoding, the ASCII constants ('*', '!', '?', 'R', 'E', 'e'), and the argument-letter list.
REQ-038 The binary-to-hex nibble conversion SHALL be one sub-module, hex_nibble_ascii.

Verification
REQ-039 ARG_BITS = 16, txReady = 1: send "V" then 0000000100000011 -> one cmdValid with cmdCode = 'V', cmdArg = 0x0103, then tx '*'.
REQ-040 statusIn channel 2 = 0xA5: send "?2" -> tx 'A','5', no cmdValid; "?9" with NUM_STATUS = 4 -> tx '!'.
REQ-041 Send "V101" then 'R' -> IDLE, no cmdValid, no tx; next "T" -> cmdValid with cmdArg = 0, then '*'.
REQ-042 TIMEOUT_CYCLES = 100: send "V1", then idle 100 cycles -> tx '!' and busy = 0.
REQ-043 Echo on, txReady low for 50 cycles during "Tx" -> once txReady rises, echo bytes precede '*', no response lost.
REQ-044 Assert rst_n = 0 while in SEND_LO with txReady = 0 -> all outputs at reset values next cycle, no txDataWr.
